// File: rtl/pll_clkgen_pkg.sv
// pll_clkgen_pkg: shared defaults and counter-width helper for the clock generator
// Provides default divide/phase/lock constants and a width function that
// never returns zero, so a divide-by-2 counter still gets one bit.
package pll_clkgen_pkg;
   localparam int DEF_LOCK_CYCLES = 8;
   localparam int DEF_DIV1 = 2;
   localparam int DEF_DIV2 = 4;
   localparam int DEF_DIV3 = 8;
   localparam int DEF_DIV4 = 2;
   localparam int DEF_PHASE1 = 0;
   localparam int DEF_PHASE2 = 0;
   localparam int DEF_PHASE3 = 0;
   localparam int DEF_PHASE4 = 1;
   function automatic int cnt_w(input int d);
      return (d < 2) ? 1 : $clog2(d);
   endfunction
endpackage

// File: rtl/pll_clkdiv.sv
// pll_clkdiv: one phase-offset divided clock with registered output
// Ports: clk (input clock), rst (sync active-high reset), en (run; low holds
// counter and output at 0), clk_o (divided clock, high for floor(DIV/2) cycles).
module pll_clkdiv
   import pll_clkgen_pkg::*;
#(
   parameter int DIV   = 2,
   parameter int PHASE = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic clk_o
);
   localparam int W = cnt_w(DIV);
   if (DIV < 2) begin : g_bad_div
      $error("pll_clkdiv: DIV must be >= 2");
   end
   if (PHASE < 0 || PHASE >= DIV) begin : g_bad_phase
      $error("pll_clkdiv: PHASE must be in [0, DIV)");
   end
   logic [W-1:0] r_cnt;
   logic [W:0]   w_sum;
   logic [W:0]   w_idx;
   // Position within the period, shifted by the phase offset and wrapped once.
   always_comb begin
      w_sum = {1'b0, r_cnt} + (W+1)'(DIV - PHASE);
      w_idx = (w_sum >= (W+1)'(DIV)) ? w_sum - (W+1)'(DIV) : w_sum;
   end
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         r_cnt <= '0;
         clk_o <= 1'b0;
      end else begin
         r_cnt <= (r_cnt == W'(DIV - 1)) ? '0 : r_cnt + 1'b1;
         clk_o <= (w_idx < (W+1)'(DIV / 2));
      end
   end
endmodule

// File: rtl/pll_clkgen.sv
// pll_clkgen: counter-based stand-in for a PLL, four divided clocks plus LOCKED
// Ports: CLK_IN1 (sole clock), RESET (sync active-high), CLK_OUT1..4 (registered
// divided clocks, 0 until locked), LOCKED (registered, set LOCK_CYCLES edges
// after reset release and held until the next reset).
module pll_clkgen
   import pll_clkgen_pkg::*;
#(
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
   parameter int DIV1   = DEF_DIV1,
   parameter int DIV2   = DEF_DIV2,
   parameter int DIV3   = DEF_DIV3,
   parameter int DIV4   = DEF_DIV4,
   parameter int PHASE1 = DEF_PHASE1,
   parameter int PHASE2 = DEF_PHASE2,
   parameter int PHASE3 = DEF_PHASE3,
   parameter int PHASE4 = DEF_PHASE4
) (
   input  logic CLK_IN1,
   input  logic RESET,
   output logic CLK_OUT1,
   output logic CLK_OUT2,
   output logic CLK_OUT3,
   output logic CLK_OUT4,
   output logic LOCKED
);
   localparam int LW = cnt_w(LOCK_CYCLES + 1);
   if (LOCK_CYCLES < 1) begin : g_bad_lock
      $error("pll_clkgen: LOCK_CYCLES must be >= 1");
   end
   logic [LW-1:0] r_lock_cnt;
   logic          w_lock_next;
   // Dividers start counting on the same edge LOCKED is set, so n=0 aligns with lock.
   assign w_lock_next = !RESET && (LOCKED || r_lock_cnt == LW'(LOCK_CYCLES - 1));
   always_ff @(posedge CLK_IN1) begin
      if (RESET) begin
         r_lock_cnt <= '0;
         LOCKED     <= 1'b0;
      end else begin
         r_lock_cnt <= (r_lock_cnt == LW'(LOCK_CYCLES)) ? r_lock_cnt : r_lock_cnt + 1'b1;
         LOCKED     <= w_lock_next;
      end
   end
   pll_clkdiv #(.DIV(DIV1), .PHASE(PHASE1)) u_div1 (.clk(CLK_IN1), .rst(RESET), .en(w_lock_next), .clk_o(CLK_OUT1));
   pll_clkdiv #(.DIV(DIV2), .PHASE(PHASE2)) u_div2 (.clk(CLK_IN1), .rst(RESET), .en(w_lock_next), .clk_o(CLK_OUT2));
   pll_clkdiv #(.DIV(DIV3), .PHASE(PHASE3)) u_div3 (.clk(CLK_IN1), .rst(RESET), .en(w_lock_next), .clk_o(CLK_OUT3));
   pll_clkdiv #(.DIV(DIV4), .PHASE(PHASE4)) u_div4 (.clk(CLK_IN1), .rst(RESET), .en(w_lock_next), .clk_o(CLK_OUT4));
endmodule

// File: tb/tb_pll_clkgen.sv
// tb_pll_clkgen: randomized self-checking bench for pll_clkgen against an edge-count model
`timescale 1ns/1ps
module tb_pll_clkgen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic o1, o2, o3, o4, lk;
   logic p1, p2, p3, p4, plk;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   edges = 0;
   logic [3:0] first_wave [16];

   always #12.5 clk = ~clk;

   pll_clkgen dut (
      .CLK_IN1(clk), .RESET(rst),
      .CLK_OUT1(o1), .CLK_OUT2(o2), .CLK_OUT3(o3), .CLK_OUT4(o4), .LOCKED(lk)
   );
   pll_clkgen #(.DIV3(3), .PHASE3(1)) dut3 (
      .CLK_IN1(clk), .RESET(rst),
      .CLK_OUT1(p1), .CLK_OUT2(p2), .CLK_OUT3(p3), .CLK_OUT4(p4), .LOCKED(plk)
   );

   // Model: count edges with reset low since the last reset; n = edges - 8.
   function automatic logic exp_clk(input int div, input int phase);
      int n;
      if (edges < 8) return 1'b0;
      n = edges - 8;
      return ((n + div - phase) % div) < (div / 2);
   endfunction

   function automatic logic exp_lock();
      return edges >= 8;
   endfunction

   task automatic step();
      @(posedge clk);
      edges = rst ? 0 : edges + 1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if ({lk, o1, o2, o3, o4, plk, p3} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset edge %0d: got lk=%b o=%b%b%b%b plk=%b p3=%b, want all 0", i, lk, o1, o2, o3, o4, plk, p3);
         end
      end
   endtask

   task automatic test_lock();
      rst = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         n_cmp++;
         if (i < 8 && {lk, o1, o2, o3, o4} !== 5'b0) begin
            n_bad++;
            $display("FAIL prelock edge %0d: got lk=%b o=%b%b%b%b, want 00000", i, lk, o1, o2, o3, o4);
         end
         if (i == 8 && {lk, o1, o2, o3, o4} !== 5'b11110) begin
            n_bad++;
            $display("FAIL lock edge: got lk=%b o=%b%b%b%b, want 1 1110", lk, o1, o2, o3, o4);
         end
      end
      first_wave[0] = {o1, o2, o3, o4};
   endtask

   task automatic test_waveforms();
      for (int n = 1; n < 16; n++) begin
         step();
         first_wave[n] = {o1, o2, o3, o4};
         n_cmp++;
         if ({o1, o2, o3, o4} !== {exp_clk(2, 0), exp_clk(4, 0), exp_clk(8, 0), exp_clk(2, 1)}) begin
            n_bad++;
            $display("FAIL wave n=%0d: got %b%b%b%b, want %b%b%b%b", n, o1, o2, o3, o4,
                     exp_clk(2, 0), exp_clk(4, 0), exp_clk(8, 0), exp_clk(2, 1));
         end
         n_cmp++;
         if (o4 !== ~o1 || lk !== 1'b1) begin
            n_bad++;
            $display("FAIL out4_inv n=%0d: got o1=%b o4=%b lk=%b, want o4=~o1 lk=1", n, o1, o4, lk);
         end
      end
   endtask

   task automatic test_relock();
      rst = 1'b1;
      step();
      n_cmp++;
      if ({lk, o1, o2, o3, o4} !== 5'b0) begin
         n_bad++;
         $display("FAIL midreset: got lk=%b o=%b%b%b%b, want 00000", lk, o1, o2, o3, o4);
      end
      rst = 1'b0;
      for (int i = 1; i < 8; i++) begin
         step();
         n_cmp++;
         if (lk !== 1'b0) begin
            n_bad++;
            $display("FAIL relock early edge %0d: got lk=%b, want 0", i, lk);
         end
      end
      for (int n = 0; n < 16; n++) begin
         step();
         n_cmp++;
         if ({o1, o2, o3, o4} !== first_wave[n] || lk !== 1'b1) begin
            n_bad++;
            $display("FAIL relock wave n=%0d: got %b%b%b%b lk=%b, want %b lk=1", n, o1, o2, o3, o4, lk, first_wave[n]);
         end
      end
   endtask

   task automatic test_div3();
      logic [5:0] pat;
      logic [5:0] want;
      want = 6'b010010;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 7; i++) step();
      for (int n = 0; n < 6; n++) begin
         step();
         pat[5-n] = p3;
      end
      n_cmp++;
      if (pat !== want) begin
         n_bad++;
         $display("FAIL div3_phase1: got %b, want %b", pat, want);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 24) == 0);
         step();
         n_cmp++;
         if ({lk, o1, o2, o3, o4, plk, p3} !== {exp_lock(), exp_clk(2, 0), exp_clk(4, 0), exp_clk(8, 0),
                                                exp_clk(2, 1), exp_lock(), exp_clk(3, 1)}) begin
            n_bad++;
            $display("FAIL random i=%0d edges=%0d: got lk=%b o=%b%b%b%b plk=%b p3=%b, want lk=%b o=%b%b%b%b p3=%b",
                     i, edges, lk, o1, o2, o3, o4, plk, p3, exp_lock(), exp_clk(2, 0), exp_clk(4, 0),
                     exp_clk(8, 0), exp_clk(2, 1), exp_clk(3, 1));
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_lock();
      test_waveforms();
      test_relock();
      test_div3();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
